mem_arbiter: RTL and testbench

- Shares the single frame-buffer memory port between NUM_REQ drawing engines: fill_rect_engine, future copy/line engines and the display fetch.
- Each requester presents the same 32-bit data, 16-bit address, 4-bit byte-enable, op and rts/rtr command interface used by fill_rect_engine.
- Round-robin grant, one registered command stage toward memory, and in-order routing of read data back to the issuing requester via a source-ID FIFO.

---
 rtl/gfx_pkg.sv | 19 +
 rtl/rd_id_fifo.sv | 54 +++++
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_pkg.sv
// Shared definitions for the frame-buffer memory command interface.
package gfx_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned WBEN_W = 4;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // One memory command as carried by a requester or the command stage.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [WBEN_W-1:0] wben;
    logic              op;
  } mem_cmd_t;

endpackage

// File: rtl/rd_id_fifo.sv
// Source-ID FIFO: remembers which requester issued each outstanding read.
module rd_id_fifo #(
  parameter int unsigned ID_W  = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_,
  input  logic                       push,
  input  logic [ID_W-1:0]            push_id,
  input  logic                       pop,
  output logic [ID_W-1:0]            pop_id,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ID_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign pop_id  = mem[rd_ptr];

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_id;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one registered memory command port among
// NUM_REQ engines, with in-order read-data routing by source ID.
module mem_arbiter
  import gfx_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 3,
  parameter int unsigned RD_DEPTH = 4,
  parameter int unsigned ID_W     = 2
) (
  input  logic                      clk,
  input  logic                      rst_,
  input  logic [NUM_REQ*DATA_W-1:0] req_in_data,
  input  logic [NUM_REQ*ADDR_W-1:0] req_in_addr,
  input  logic [NUM_REQ*WBEN_W-1:0] req_in_wben,
  input  logic [NUM_REQ-1:0]        req_in_op,
  input  logic [NUM_REQ-1:0]        req_in_rts,
  output logic [NUM_REQ-1:0]        req_out_rtr,
  output logic [DATA_W-1:0]         req_out_rdata,
  output logic [NUM_REQ-1:0]        req_out_rvalid,
  output logic [ADDR_W-1:0]         mem_out_addr,
  output logic [DATA_W-1:0]         mem_out_data,
  output logic [WBEN_W-1:0]         mem_out_wben,
  output logic                      mem_out_op,
  output logic                      mem_out_rts,
  input  logic                      mem_in_rtr,
  input  logic [DATA_W-1:0]         mem_in_rdata,
  input  logic                      mem_in_rvalid,
  output logic                      err_rd_underflow
);

  localparam int unsigned CNT_W = $clog2(RD_DEPTH + 1);

  logic [ID_W-1:0]    ptr_q;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_vld;
  logic               stage_free;
  logic               xfer;
  logic               credit_ok;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] head_onehot;
  mem_cmd_t           sel_cmd;
  mem_cmd_t           cmd_q;

  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_push;
  logic               fifo_pop;
  logic [ID_W-1:0]    fifo_head;

  assign stage_free = ~mem_out_rts | mem_in_rtr;
  assign xfer       = rst_ & stage_free & grant_vld;
  assign fifo_push  = xfer & (sel_cmd.op == OP_READ) & ~fifo_full;
  assign fifo_pop   = mem_in_rvalid & ~fifo_empty;

  assign mem_out_addr = cmd_q.addr;
  assign mem_out_data = cmd_q.data;
  assign mem_out_wben = cmd_q.wben;
  assign mem_out_op   = cmd_q.op;

  // Reads need a free tag (registered count only); writes always qualify.
  always_comb begin
    credit_ok = (fifo_count < CNT_W'(RD_DEPTH));
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_in_rts[i] & (req_in_op[i] | credit_ok);
    end
  end

  // Round-robin search: indices at/after ptr first, then the wrapped ones.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!grant_vld && eligible[i] && (i >= 32'(ptr_q))) begin
        grant_vld = 1'b1;
        grant_idx = ID_W'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!grant_vld && eligible[i] && (i < 32'(ptr_q))) begin
        grant_vld = 1'b1;
        grant_idx = ID_W'(i);
      end
    end
  end

  // Winner's command mux and one-hot ready; ready is held low in reset.
  always_comb begin
    sel_cmd = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_out_rtr[i] = xfer && (grant_idx == ID_W'(i));
      head_onehot[i] = (fifo_head == ID_W'(i));
      if (grant_idx == ID_W'(i)) begin
        sel_cmd.addr = req_in_addr[i*ADDR_W +: ADDR_W];
        sel_cmd.data = req_in_data[i*DATA_W +: DATA_W];
        sel_cmd.wben = req_in_wben[i*WBEN_W +: WBEN_W];
        sel_cmd.op   = req_in_op[i];
      end
    end
  end

  // Command stage and round-robin pointer; fields freeze while stalled.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cmd_q       <= '0;
      mem_out_rts <= 1'b0;
      ptr_q       <= '0;
    end else if (xfer) begin
      cmd_q       <= sel_cmd;
      mem_out_rts <= 1'b1;
      ptr_q       <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end else if (mem_in_rtr) begin
      mem_out_rts <= 1'b0;
    end
  end

  // Read return routing and sticky underflow flag.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      req_out_rvalid   <= '0;
      req_out_rdata    <= '0;
      err_rd_underflow <= 1'b0;
    end else begin
      req_out_rvalid <= '0;
      if (fifo_pop) begin
        req_out_rvalid <= head_onehot;
        req_out_rdata  <= mem_in_rdata;
      end
      if (mem_in_rvalid && fifo_empty) err_rd_underflow <= 1'b1;
    end
  end

  rd_id_fifo #(
    .ID_W  (ID_W),
    .DEPTH (RD_DEPTH)
  ) u_rd_id_fifo (
    .clk     (clk),
    .rst_    (rst_),
    .push    (fifo_push),
    .push_id (grant_idx),
    .pop     (fifo_pop),
    .pop_id  (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grant order, stall, read routing, credit,
// underflow and asynchronous reset.
module tb_mem_arbiter;

  logic         clk;
  logic         rst_;
  logic [95:0]  req_in_data;
  logic [47:0]  req_in_addr;
  logic [11:0]  req_in_wben;
  logic [2:0]   req_in_op;
  logic [2:0]   req_in_rts;
  logic [2:0]   req_out_rtr;
  logic [31:0]  req_out_rdata;
  logic [2:0]   req_out_rvalid;
  logic [15:0]  mem_out_addr;
  logic [31:0]  mem_out_data;
  logic [3:0]   mem_out_wben;
  logic         mem_out_op;
  logic         mem_out_rts;
  logic         mem_in_rtr;
  logic [31:0]  mem_in_rdata;
  logic         mem_in_rvalid;
  logic         err_rd_underflow;

  logic [31:0]  d [3];
  logic [15:0]  a [3];
  logic [3:0]   w [3];
  logic [2:0]   oh;

  int vectors;
  int miscompares;

  assign req_in_data = {d[2], d[1], d[0]};
  assign req_in_addr = {a[2], a[1], a[0]};
  assign req_in_wben = {w[2], w[1], w[0]};

  mem_arbiter #(
    .NUM_REQ  (3),
    .RD_DEPTH (4),
    .ID_W     (2)
  ) dut (
    .clk              (clk),
    .rst_             (rst_),
    .req_in_data      (req_in_data),
    .req_in_addr      (req_in_addr),
    .req_in_wben      (req_in_wben),
    .req_in_op        (req_in_op),
    .req_in_rts       (req_in_rts),
    .req_out_rtr      (req_out_rtr),
    .req_out_rdata    (req_out_rdata),
    .req_out_rvalid   (req_out_rvalid),
    .mem_out_addr     (mem_out_addr),
    .mem_out_data     (mem_out_data),
    .mem_out_wben     (mem_out_wben),
    .mem_out_op       (mem_out_op),
    .mem_out_rts      (mem_out_rts),
    .mem_in_rtr       (mem_in_rtr),
    .mem_in_rdata     (mem_in_rdata),
    .mem_in_rvalid    (mem_in_rvalid),
    .err_rd_underflow (err_rd_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] i, input logic op, input logic [15:0] addr,
                         input logic [31:0] data);
    req_in_op[i] = op;
    a[i] = addr;
    d[i] = data;
    w[i] = 4'hF;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_          = 1'b0;
    req_in_rts    = '0;
    req_in_op     = '0;
    mem_in_rtr    = 1'b1;
    mem_in_rdata  = '0;
    mem_in_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d[i] = '0;
      a[i] = '0;
      w[i] = '0;
    end

    // Reset state, with requests already pending.
    repeat (2) @(posedge clk);
    #1;
    req_in_rts = 3'b111;
    req_in_op  = 3'b111;
    #1;
    check("rst_rtr",    32'(req_out_rtr),      32'h0);
    check("rst_rts",    32'(mem_out_rts),      32'h0);
    check("rst_addr",   32'(mem_out_addr),     32'h0);
    check("rst_data",   mem_out_data,          32'h0);
    check("rst_rvalid", 32'(req_out_rvalid),   32'h0);
    check("rst_rdata",  req_out_rdata,         32'h0);
    check("rst_err",    32'(err_rd_underflow), 32'h0);
    req_in_rts = '0;
    #2 rst_ = 1'b1;

    // Fairness: three continuous writers, expected order 0,1,2,0,1,2.
    for (int i = 0; i < 3; i++) set_req(2'(i), 1'b1, 16'h1000 + 16'(i), 32'hF000_0000 + 32'(i));
    req_in_rts = 3'b111;
    for (int k = 0; k < 6; k++) begin
      oh = 3'b001 << (k % 3);
      #1 check("fair_rtr", 32'(req_out_rtr), 32'(oh));
      tick();
      check("fair_addr", 32'(mem_out_addr), 32'h1000 + 32'(k % 3));
      check("fair_rts",  32'(mem_out_rts),  32'h1);
    end
    req_in_rts = '0;

    // Single writer on requester 1.
    set_req(2'd1, 1'b1, 16'h0010, 32'hAABB_CCDD);
    req_in_rts = 3'b010;
    #1 check("sw_rtr", 32'(req_out_rtr), 32'h2);
    tick();
    check("sw_rts",  32'(mem_out_rts),  32'h1);
    check("sw_addr", 32'(mem_out_addr), 32'h0010);
    check("sw_data", mem_out_data,      32'hAABB_CCDD);
    check("sw_wben", 32'(mem_out_wben), 32'hF);
    check("sw_op",   32'(mem_out_op),   32'h1);
    req_in_rts = '0;

    // Stall: pointer at 2, requesters 0 and 2 writing.
    set_req(2'd0, 1'b1, 16'h00A0, 32'hA0A0_A0A0);
    set_req(2'd2, 1'b1, 16'h00C0, 32'hC0C0_C0C0);
    req_in_rts = 3'b101;
    #1 check("st_rtr0", 32'(req_out_rtr), 32'h4);
    tick();
    check("st_addr0", 32'(mem_out_addr), 32'h00C0);
    mem_in_rtr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 check("st_rtr_hold", 32'(req_out_rtr), 32'h0);
      tick();
      check("st_addr_hold", 32'(mem_out_addr), 32'h00C0);
      check("st_data_hold", mem_out_data,      32'hC0C0_C0C0);
      check("st_rts_hold",  32'(mem_out_rts),  32'h1);
    end
    mem_in_rtr = 1'b1;
    #1 check("st_rtr_rel", 32'(req_out_rtr), 32'h1);
    tick();
    check("st_addr_rel", 32'(mem_out_addr), 32'h00A0);
    req_in_rts = '0;

    // Read routing: req2 then req0; returns come back in issue order.
    set_req(2'd2, 1'b0, 16'h0100, 32'h0);
    req_in_rts = 3'b100;
    #1 check("rd_rtr2", 32'(req_out_rtr), 32'h4);
    tick();
    check("rd_addr2", 32'(mem_out_addr), 32'h0100);
    check("rd_op2",   32'(mem_out_op),   32'h0);
    set_req(2'd0, 1'b0, 16'h0200, 32'h0);
    req_in_rts = 3'b001;
    #1 check("rd_rtr0", 32'(req_out_rtr), 32'h1);
    tick();
    check("rd_addr0", 32'(mem_out_addr), 32'h0200);
    req_in_rts = '0;
    mem_in_rvalid = 1'b1;
    mem_in_rdata  = 32'h1111_1111;
    tick();
    check("rd_rvalid_a", 32'(req_out_rvalid), 32'h4);
    check("rd_rdata_a",  req_out_rdata,       32'h1111_1111);
    mem_in_rdata = 32'h2222_2222;
    tick();
    check("rd_rvalid_b", 32'(req_out_rvalid), 32'h1);
    check("rd_rdata_b",  req_out_rdata,       32'h2222_2222);
    mem_in_rvalid = 1'b0;
    tick();
    check("rd_rvalid_idle", 32'(req_out_rvalid), 32'h0);
    check("rd_rdata_hold",  req_out_rdata,       32'h2222_2222);

    // Credit: four reads fill the tag FIFO; a fifth read must wait.
    set_req(2'd0, 1'b0, 16'h0300, 32'h0);
    req_in_rts = 3'b001;
    for (int k = 0; k < 4; k++) begin
      #1 check("cr_rd_rtr", 32'(req_out_rtr), 32'h1);
      tick();
    end
    set_req(2'd1, 1'b1, 16'h0400, 32'h4444_0000);
    req_in_rts = 3'b011;
    #1 check("cr_wr_rtr", 32'(req_out_rtr), 32'h2);
    tick();
    check("cr_wr_addr", 32'(mem_out_addr), 32'h0400);
    #1 check("cr_wr_over_rd", 32'(req_out_rtr), 32'h2);
    tick();
    req_in_rts = 3'b001;
    #1 check("cr_blocked", 32'(req_out_rtr), 32'h0);
    mem_in_rvalid = 1'b1;
    mem_in_rdata  = 32'h3333_3333;
    #1 check("cr_same_cycle", 32'(req_out_rtr), 32'h0);
    tick();
    mem_in_rvalid = 1'b0;
    check("cr_rvalid", 32'(req_out_rvalid), 32'h1);
    check("cr_rdata",  req_out_rdata,       32'h3333_3333);
    #1 check("cr_after_pop", 32'(req_out_rtr), 32'h1);
    tick();
    check("cr_rd_addr", 32'(mem_out_addr), 32'h0300);
    check("cr_rd_op",   32'(mem_out_op),   32'h0);
    req_in_rts = '0;
    mem_in_rvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mem_in_rdata = 32'h5000_0000 + 32'(k);
      tick();
      check("drain_rvalid", 32'(req_out_rvalid), 32'h1);
      check("drain_rdata",  req_out_rdata,       32'h5000_0000 + 32'(k));
    end
    mem_in_rvalid = 1'b0;
    check("drain_no_err", 32'(err_rd_underflow), 32'h0);

    // Underflow: return strobe with no outstanding read.
    mem_in_rvalid = 1'b1;
    mem_in_rdata  = 32'hDEAD_BEEF;
    tick();
    mem_in_rvalid = 1'b0;
    check("uf_err",    32'(err_rd_underflow), 32'h1);
    check("uf_rvalid", 32'(req_out_rvalid),   32'h0);
    check("uf_rdata",  req_out_rdata,         32'h5000_0003);
    tick();
    check("uf_sticky", 32'(err_rd_underflow), 32'h1);

    // Reset mid-burst with a read tag outstanding.
    set_req(2'd1, 1'b0, 16'h0500, 32'h0);
    set_req(2'd2, 1'b1, 16'h0600, 32'h6666_6666);
    req_in_rts = 3'b110;
    #1 check("mr_rtr", 32'(req_out_rtr), 32'h2);
    tick();
    check("mr_addr", 32'(mem_out_addr), 32'h0500);
    #2 rst_ = 1'b0;
    #1;
    check("mr_rst_rts",    32'(mem_out_rts),      32'h0);
    check("mr_rst_addr",   32'(mem_out_addr),     32'h0);
    check("mr_rst_rtr",    32'(req_out_rtr),      32'h0);
    check("mr_rst_err",    32'(err_rd_underflow), 32'h0);
    check("mr_rst_rvalid", 32'(req_out_rvalid),   32'h0);
    check("mr_rst_rdata",  req_out_rdata,         32'h0);
    tick();
    #2 rst_ = 1'b1;
    #1 check("mr_ptr_zero", 32'(req_out_rtr), 32'h2);
    req_in_rts    = '0;
    mem_in_rvalid = 1'b1;
    tick();
    mem_in_rvalid = 1'b0;
    check("mr_fifo_empty", 32'(err_rd_underflow), 32'h1);
    check("mr_no_rvalid",  32'(req_out_rvalid),   32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
